// File: rtl/antares_pipe_stage.sv
// Elastic valid/ready pipeline register for the Antares core, with an optional
// two-entry skid buffer that turns up_ready into a registered signal.
module antares_pipe_stage #(
    parameter int DATA_WIDTH = 128,
    parameter int CTRL_WIDTH = 16,
    parameter int SKID       = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic [CTRL_WIDTH-1:0] up_ctrl,
    input  logic                  flush,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_data,
    output logic [CTRL_WIDTH-1:0] dn_ctrl,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
    logic                  up_ready_q, up_ready_d;
    logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;

    logic head_valid;
    logic accept;
    logic drain;

    assign head_valid = (state_q != EMPTY);
    assign up_ready   = (SKID != 0) ? up_ready_q : (~head_valid | dn_ready);
    // A beat offered during a flush is dropped, so it never counts as accepted.
    assign accept     = up_valid & up_ready & ~flush;
    assign drain      = head_valid & dn_ready;

    always_comb begin
        state_d       = state_q;
        main_data_d   = main_data_q;
        main_ctrl_d   = main_ctrl_q;
        skid_data_d   = skid_data_q;
        skid_ctrl_d   = skid_ctrl_q;
        stall_count_d = stall_count_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_data_d = up_data;
                    main_ctrl_d = up_ctrl;
                    state_d     = HALF;
                end
            end
            HALF: begin
                if (accept && drain) begin
                    main_data_d = up_data;
                    main_ctrl_d = up_ctrl;
                end else if (accept && (SKID != 0)) begin
                    skid_data_d = up_data;
                    skid_ctrl_d = up_ctrl;
                    state_d     = FULL;
                end else if (drain) begin
                    main_ctrl_d = '0;
                    state_d     = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    skid_ctrl_d = '0;
                    state_d     = HALF;
                end
            end
            default: begin
                main_ctrl_d = '0;
                skid_ctrl_d = '0;
                state_d     = EMPTY;
            end
        endcase

        // Flush kills control but deliberately leaves payload bits untouched.
        if (flush) begin
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            state_d     = EMPTY;
        end

        up_ready_d = (state_d != FULL);

        if (head_valid && !dn_ready && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            main_data_q   <= '0;
            main_ctrl_q   <= '0;
            skid_data_q   <= '0;
            skid_ctrl_q   <= '0;
            up_ready_q    <= 1'b1;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            main_data_q   <= main_data_d;
            main_ctrl_q   <= main_ctrl_d;
            skid_data_q   <= skid_data_d;
            skid_ctrl_q   <= skid_ctrl_d;
            up_ready_q    <= up_ready_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign dn_valid    = head_valid;
    assign dn_data     = main_data_q;
    assign dn_ctrl     = main_ctrl_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_antares_pipe_stage.sv
// Directed bench for antares_pipe_stage: a SKID=1 instance with default widths
// and a SKID=0 instance with a 4-bit stall counter.
module tb_antares_pipe_stage;

    logic         clk;
    logic         rst;

    logic         up_valid;
    logic         up_ready;
    logic [127:0] up_data;
    logic [15:0]  up_ctrl;
    logic         flush;
    logic         dn_valid;
    logic         dn_ready;
    logic [127:0] dn_data;
    logic [15:0]  dn_ctrl;
    logic [15:0]  stall_count;

    logic         s0_up_valid;
    logic         s0_up_ready;
    logic [127:0] s0_up_data;
    logic [15:0]  s0_up_ctrl;
    logic         s0_flush;
    logic         s0_dn_valid;
    logic         s0_dn_ready;
    logic [127:0] s0_dn_data;
    logic [15:0]  s0_dn_ctrl;
    logic [3:0]   s0_stall_count;

    int vectors;
    int miscompares;

    antares_pipe_stage #(
        .DATA_WIDTH(128), .CTRL_WIDTH(16), .SKID(1), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_ctrl(up_ctrl),
        .flush(flush),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data), .dn_ctrl(dn_ctrl),
        .stall_count(stall_count)
    );

    antares_pipe_stage #(
        .DATA_WIDTH(128), .CTRL_WIDTH(16), .SKID(0), .CNT_WIDTH(4)
    ) dut0 (
        .clk(clk), .rst(rst),
        .up_valid(s0_up_valid), .up_ready(s0_up_ready), .up_data(s0_up_data), .up_ctrl(s0_up_ctrl),
        .flush(s0_flush),
        .dn_valid(s0_dn_valid), .dn_ready(s0_dn_ready), .dn_data(s0_dn_data), .dn_ctrl(s0_dn_ctrl),
        .stall_count(s0_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ctrlOf(input logic [127:0] d);
        return {8'hC5, d[7:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives the SKID=1 instance for one cycle; returns 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic [127:0] d, input logic rdy, input logic fl);
        up_valid = v;
        up_data  = d;
        up_ctrl  = ctrlOf(d);
        dn_ready = rdy;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] send_val;
        logic [127:0] exp_out;
        logic         exp_valid;
        logic         rdy;
        logic         exp_rdy;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        up_valid = 0; up_data = '0; up_ctrl = '0; flush = 0; dn_ready = 0;
        s0_up_valid = 0; s0_up_data = '0; s0_up_ctrl = '0; s0_flush = 0; s0_dn_ready = 0;

        // Reset held three cycles while upstream offers garbage
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 128'hDEAD, 1'b1, 1'b0);
        rst = 1'b0;
        checkOutput("rst_dn_valid", dn_valid, 0);
        checkOutput("rst_dn_ctrl", dn_ctrl, 0);
        checkOutput("rst_dn_data", dn_data, 0);
        checkOutput("rst_up_ready", up_ready, 1);
        checkOutput("rst_stall", stall_count, 0);
        checkOutput("rst0_dn_valid", s0_dn_valid, 0);
        checkOutput("rst0_stall", s0_stall_count, 0);

        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 128'(k), 1'b1, 1'b0);
            checkOutput("stream_valid", dn_valid, 1);
            checkOutput("stream_data", dn_data, 128'(k));
            checkOutput("stream_ctrl", dn_ctrl, ctrlOf(128'(k)));
        end
        applyStimulus(1'b0, 128'hFF, 1'b1, 1'b0);
        checkOutput("bubble_valid", dn_valid, 0);
        checkOutput("bubble_ctrl", dn_ctrl, 0);
        checkOutput("bubble_data_held", dn_data, 8);
        checkOutput("stream_stall", stall_count, 0);

        // Skid fill with downstream stalled
        applyStimulus(1'b1, 128'hA1, 1'b0, 1'b0);
        checkOutput("skid_a_data", dn_data, 128'hA1);
        checkOutput("skid_a_ready", up_ready, 1);
        applyStimulus(1'b1, 128'hB2, 1'b0, 1'b0);
        checkOutput("skid_full_ready", up_ready, 0);
        checkOutput("skid_b_head", dn_data, 128'hA1);
        checkOutput("skid_b_stall", stall_count, 1);
        applyStimulus(1'b1, 128'hC3, 1'b0, 1'b0);
        checkOutput("skid_c_ready", up_ready, 0);
        applyStimulus(1'b1, 128'h99, 1'b0, 1'b0);
        checkOutput("skid_hold_head", dn_data, 128'hA1);
        checkOutput("skid_hold_stall", stall_count, 3);
        applyStimulus(1'b1, 128'hC3, 1'b1, 1'b0);
        checkOutput("skid_out_b", dn_data, 128'hB2);
        checkOutput("skid_out_b_ctrl", dn_ctrl, ctrlOf(128'hB2));
        checkOutput("skid_ready_back", up_ready, 1);
        applyStimulus(1'b1, 128'hC3, 1'b1, 1'b0);
        checkOutput("skid_out_c", dn_data, 128'hC3);
        checkOutput("skid_out_c_valid", dn_valid, 1);
        applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
        checkOutput("skid_drained", dn_valid, 0);
        checkOutput("skid_stall_total", stall_count, 3);

        // Flush while FULL with a beat on the input
        applyStimulus(1'b1, 128'hE5, 1'b0, 1'b0);
        applyStimulus(1'b1, 128'hF6, 1'b0, 1'b0);
        checkOutput("pre_flush_ready", up_ready, 0);
        applyStimulus(1'b1, 128'hD4, 1'b0, 1'b1);
        checkOutput("flush_valid", dn_valid, 0);
        checkOutput("flush_ctrl", dn_ctrl, 0);
        checkOutput("flush_data_held", dn_data, 128'hE5);
        checkOutput("flush_ready", up_ready, 1);
        checkOutput("flush_stall_kept", stall_count, 5);
        applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
        checkOutput("flush_no_d", dn_valid, 0);
        applyStimulus(1'b1, 128'h17, 1'b1, 1'b0);
        checkOutput("post_flush_g", dn_data, 128'h17);
        checkOutput("post_flush_g_ctrl", dn_ctrl, ctrlOf(128'h17));
        applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
        checkOutput("post_flush_empty", dn_valid, 0);

        // SKID=0: toggling dn_ready against a continuous upstream
        send_val  = 1;
        exp_out   = 1;
        exp_valid = 0;
        for (int i = 0; i < 12; i++) begin
            rdy         = (i % 2 == 0);
            s0_up_valid = 1'b1;
            s0_up_data  = send_val;
            s0_up_ctrl  = ctrlOf(send_val);
            s0_dn_ready = rdy;
            #1;
            exp_rdy = ~exp_valid | rdy;
            checkOutput("s0_up_ready", s0_up_ready, exp_rdy);
            if (exp_valid && rdy) begin
                checkOutput("s0_order", s0_dn_data, exp_out);
                exp_out++;
            end
            @(posedge clk);
            #1;
            if (exp_rdy) send_val++;
            exp_valid = exp_rdy | exp_valid;
            checkOutput("s0_valid", s0_dn_valid, exp_valid);
        end
        checkOutput("s0_last_head", s0_dn_data, exp_out);
        checkOutput("s0_last_ctrl", s0_dn_ctrl, ctrlOf(exp_out));
        s0_up_valid = 1'b0;
        s0_dn_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("s0_drained", s0_dn_valid, 0);
        checkOutput("s0_drained_ctrl", s0_dn_ctrl, 0);

        // SKID=0 stall counter saturation at 15
        s0_up_valid = 1'b1;
        s0_up_data  = 128'h55;
        s0_up_ctrl  = ctrlOf(128'h55);
        s0_dn_ready = 1'b0;
        @(posedge clk);
        #1;
        s0_up_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("s0_stall_sat", s0_stall_count, 15);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("s0_stall_hold", s0_stall_count, 15);
        checkOutput("s0_stall_head", s0_dn_data, 128'h55);

        // Reset while FULL, together with flush and a valid beat
        applyStimulus(1'b1, 128'h21, 1'b0, 1'b0);
        applyStimulus(1'b1, 128'h32, 1'b0, 1'b0);
        checkOutput("pre_rst_full", up_ready, 0);
        rst = 1'b1;
        applyStimulus(1'b1, 128'h43, 1'b0, 1'b1);
        rst = 1'b0;
        checkOutput("rst2_dn_valid", dn_valid, 0);
        checkOutput("rst2_dn_ctrl", dn_ctrl, 0);
        checkOutput("rst2_dn_data", dn_data, 0);
        checkOutput("rst2_up_ready", up_ready, 1);
        checkOutput("rst2_stall", stall_count, 0);
        checkOutput("rst2_s0_stall", s0_stall_count, 0);
        applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
        checkOutput("rst2_stays_empty", dn_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
